sar_adc_ctrl: RTL and testbench

Successive-approximation ADC controller: the capture-side counterpart of the 4-bit DAC waveform generator. It drives the same resistor-ladder DAC with trial codes and reads back an external analog comparator (Vin ≥ Vdac). It then performs an MSB-first binary search and presents the converted code with a one-cycle valid strobe. It sits between the board's DAC/comparator pins and the lab display/logging logic.

---
 rtl/sar_adc_ctrl.sv | 112 +++++++++++
 tb/tb_sar_adc_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: MSB-first binary search over a DAC/comparator pair.
// Optional ADC_CONT_EN: back-to-back conversions without passing through IDLE while start stays high.
module sar_adc_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp,
  output logic [WIDTH-1:0] dac_out,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [WIDTH-1:0] CODE_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CODE_MSB = CODE_ONE << (WIDTH - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] resolved;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      code_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      dac_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      dac_q    <= dac_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    dac_d    = dac_q;
    result_d = result_q;
    valid_d  = 1'b0;
    // Code with the bit under trial replaced by the comparator decision.
    resolved = code_q;
    resolved[idx_q] = cmp;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CONV;
          code_d  = '0;
          idx_d   = IDX_MSB;
          cnt_d   = '0;
          dac_d   = CODE_MSB;
        end
      end
      CONV: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          code_d = resolved;
          if (idx_q != '0) begin
            dac_d = resolved | (CODE_ONE << (idx_q - 1'b1));
            idx_d = idx_q - 1'b1;
            cnt_d = '0;
          end else begin
            result_d = resolved;
            dac_d    = resolved;
            valid_d  = 1'b1;
            state_d  = IDLE;
`ifdef ADC_CONT_EN
            if (start) begin
              state_d = CONV;
              code_d  = '0;
              idx_d   = IDX_MSB;
              cnt_d   = '0;
              dac_d   = CODE_MSB;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dac_out = dac_q;
  assign result  = result_q;
  assign valid   = valid_q;
  assign busy    = (state_q == CONV);

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: table of conversions plus reset, back-to-back and settle corner cases.
module tb_sar_adc_ctrl;

  logic       clk;
  logic       rst;
  logic       start, start3;
  logic       cmp, cmp3;
  logic [3:0] vin, vin3;
  logic       noise3;
  logic [3:0] dac_out, result, dac3, result3;
  logic       valid, busy, valid3, busy3;

  int total = 0;
  int bad   = 0;

  sar_adc_ctrl #(.WIDTH(4), .SETTLE(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .cmp(cmp),
    .dac_out(dac_out), .result(result), .valid(valid), .busy(busy)
  );

  sar_adc_ctrl #(.WIDTH(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .cmp(cmp3),
    .dac_out(dac3), .result(result3), .valid(valid3), .busy(busy3)
  );

  // Analog comparator models; the second one can be disturbed off its sampling edges.
  assign cmp  = (vin >= dac_out);
  assign cmp3 = (vin3 >= dac3) ^ noise3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] vin;
    logic [3:0] seq [4];
    logic [3:0] res;
  } vec_t;

  vec_t vecs [6];

  task automatic set_vec(input int i, input logic [3:0] v, input logic [3:0] s0,
                         input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] s3, input logic [3:0] r);
    vecs[i].vin = v;
    vecs[i].seq[0] = s0;
    vecs[i].seq[1] = s1;
    vecs[i].seq[2] = s2;
    vecs[i].seq[3] = s3;
    vecs[i].res = r;
  endtask

  // One start pulse, then every edge up to completion and one edge beyond.
  task automatic run_conv(input vec_t v);
    vin   = v.vin;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("e0_busy", busy, 1);
    check("e0_dac", dac_out, v.seq[0]);
    check("e0_valid", valid, 0);
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j < 8) begin
        check("conv_dac", dac_out, v.seq[j / 2]);
        check("conv_busy", busy, 1);
        check("conv_valid", valid, 0);
      end else begin
        check("done_valid", valid, 1);
        check("done_result", result, v.res);
        check("done_dac", dac_out, v.res);
        check("done_busy", busy, 0);
      end
    end
    tick();
    check("post_valid", valid, 0);
    check("post_result", result, v.res);
    check("post_dac", dac_out, v.res);
    check("post_busy", busy, 0);
  endtask

  initial begin
    int  cyc;
    int  nvalid;
    bit  seen;
    vec_t v9;

    rst = 1'b0; start = 1'b0; start3 = 1'b0;
    vin = '0; vin3 = '0; noise3 = 1'b0;

    set_vec(0,  9, 8, 12, 10,  9,  9);
    set_vec(1,  0, 8,  4,  2,  1,  0);
    set_vec(2, 15, 8, 12, 14, 15, 15);
    set_vec(3, 10, 8, 12, 10, 11, 10);
    set_vec(4,  6, 8,  4,  6,  7,  6);
    set_vec(5,  7, 8,  4,  6,  7,  7);
    v9 = vecs[0];

    #12;
    check("rst_dac", dac_out, 0);
    check("rst_result", result, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    tick();
    tick();
    check("idle_busy", busy, 0);

    foreach (vecs[i]) run_conv(vecs[i]);

    // Asynchronous reset in the middle of a conversion.
    run_conv(v9);
    vin = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    check("arst_dac", dac_out, 0);
    check("arst_result", result, 0);
    check("arst_valid", valid, 0);
    check("arst_busy", busy, 0);
    #1 rst = 1'b1;
    tick();
    tick();
    check("arst_idle_busy", busy, 0);
    check("arst_idle_result", result, 0);
    run_conv(v9);

    // start raised mid-conversion is ignored; exactly one valid pulse.
    vin = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    nvalid = 0;
    for (int j = 1; j <= 11; j++) begin
      start = (j == 3 || j == 5);
      tick();
      start = 1'b0;
      if (valid) nvalid++;
      if (j == 8) check("mid_valid_at8", valid, 1);
    end
    check("mid_nvalid", nvalid, 1);
    check("mid_result", result, 6);
    check("mid_busy_after", busy, 0);

    // start held high across conversions; period depends on continuous mode.
    vin = 4'd3; start = 1'b1;
    tick();
    cyc = 0; seen = 1'b0;
    for (int j = 0; j < 40 && !seen; j++) begin
      tick();
      cyc++;
      if (valid) seen = 1'b1;
    end
    check("held_first_seen", seen, 1);
    check("held_first_lat", cyc, 8);
    check("held_first_res", result, 3);
    vin = 4'd10;
    cyc = 0; seen = 1'b0;
    for (int j = 0; j < 40 && !seen; j++) begin
      tick();
      cyc++;
      if (valid) seen = 1'b1;
      else check("held_busy_between", busy, 1);
    end
    start = 1'b0;
    check("held_second_seen", seen, 1);
    check("held_second_res", result, 10);
`ifdef ADC_CONT_EN
    check("held_period", cyc, 8);
    check("held_busy_at_valid", busy, 1);
`else
    check("held_period", cyc, 9);
    check("held_busy_at_valid", busy, 0);
`endif
    repeat (12) tick();
    check("held_idle_busy", busy, 0);

    // SETTLE=3 with comparator disturbed between sampling edges.
    vin3 = 4'd5; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check("s3_e0_dac", dac3, 8);
    for (int j = 1; j <= 13; j++) begin
      noise3 = (j % 3 != 0);
      tick();
      noise3 = 1'b0;
      if (j < 12) begin
        case (j / 3)
          0: check("s3_dac", dac3, 8);
          1: check("s3_dac", dac3, 4);
          2: check("s3_dac", dac3, 6);
          default: check("s3_dac", dac3, 5);
        endcase
        check("s3_valid", valid3, 0);
        check("s3_busy", busy3, 1);
      end else if (j == 12) begin
        check("s3_done_valid", valid3, 1);
        check("s3_done_result", result3, 5);
        check("s3_done_busy", busy3, 0);
      end else begin
        check("s3_post_valid", valid3, 0);
        check("s3_post_result", result3, 5);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d want=%0d", 1, 0);
    $fatal(1, "bench timeout");
  end

endmodule
